// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot time-multiplexed link (transmit and receive sides).
package tdm_pkg;

  // Number of time slots per frame and the symbol width carried in each slot.
  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  // Receiver framing state: UNLOCKED until a start-of-frame is seen, then S0..S3
  // name the slot the next valid beat will fill.
  typedef enum logic [2:0] {
    UNLOCKED,
    S0,
    S1,
    S2,
    S3
  } state_t;

endpackage

// File: rtl/tdm_demux.sv
// Receive-side demultiplexer: aligns to the start-of-frame marker, collects four
// slots into staging registers and publishes all four channels together with a
// one-cycle valid pulse.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int W           = 2,
  parameter bit BIT_SWAP    = 1'b1,
  parameter bit REQUIRE_SOF = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         din_sof,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         y_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err
);

  state_t       state, state_nxt;
  logic [W-1:0] din_rev, s;
  logic [W-1:0] stage0, stage1, stage2;
  logic [2:0]   stage_we;
  logic         out_we;
  logic         err;

  // Symbol mapping: optionally reverse the bit order to undo the transmitter's lane swap.
  always_comb begin
    din_rev = '0;
    for (int i = 0; i < W; i++) din_rev[i] = din[W-1-i];
    s = BIT_SWAP ? din_rev : din;
  end

  // Next-state decode plus the load strobes for staging and output registers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_nxt = state;
    stage_we  = '0;
    out_we    = 1'b0;
    err       = 1'b0;
    if (din_valid) begin
      unique case (state)
        UNLOCKED: begin
          if (din_sof) begin
            stage_we[0] = 1'b1;
            state_nxt   = S1;
          end
        end
        S0: begin
          if (din_sof || !REQUIRE_SOF) begin
            stage_we[0] = 1'b1;
            state_nxt   = S1;
          end else begin
            err       = 1'b1;
            state_nxt = UNLOCKED;
          end
        end
        S1, S2, S3: begin
          if (din_sof) begin
            // Marker arrived mid-frame: drop the partial frame and restart on this beat.
            err         = 1'b1;
            stage_we[0] = 1'b1;
            state_nxt   = S1;
          end else if (state == S1) begin
            stage_we[1] = 1'b1;
            state_nxt   = S2;
          end else if (state == S2) begin
            stage_we[2] = 1'b1;
            state_nxt   = S3;
          end else begin
            out_we    = 1'b1;
            state_nxt = S0;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= UNLOCKED;
    else     state <= state_nxt;
  end

  // Staging and output registers; slot 3 goes straight from the link into y3.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: staging is cleared on reset even though it is always rewritten before use,
      // so a freshly reset receiver has fully defined internal state.
      stage0   <= '0;
      stage1   <= '0;
      stage2   <= '0;
      y0       <= '0;
      y1       <= '0;
      y2       <= '0;
      y3       <= '0;
      y_valid  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      y_valid  <= out_we;
      sync_err <= err;
      if (stage_we[0]) stage0 <= s;
      if (stage_we[1]) stage1 <= s;
      if (stage_we[2]) stage2 <= s;
      if (out_we) begin
        y0 <= stage0;
        y1 <= stage1;
        y2 <= stage2;
        y3 <= s;
      end
    end
  end

  // Status decode straight from the registered state.
  always_comb begin
    locked = (state != UNLOCKED);
    unique case (state)
      S1:      slot = 2'd1;
      S2:      slot = 2'd2;
      S3:      slot = 2'd3;
      default: slot = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: two instances (straight/strict and swapped/lenient)
// share one stimulus stream; a list-based reference model predicts each cycle.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int W      = 2;
  localparam bit SWAP_A = 1'b0;
  localparam bit REQ_A  = 1'b1;
  localparam bit SWAP_B = 1'b1;
  localparam bit REQ_B  = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_sof = 1'b0;

  logic [W-1:0] a_y0, a_y1, a_y2, a_y3, b_y0, b_y1, b_y2, b_y3;
  logic         a_yv, a_lk, a_err, b_yv, b_lk, b_err;
  logic [1:0]   a_slot, b_slot;

  tdm_demux #(.W(W), .BIT_SWAP(SWAP_A), .REQUIRE_SOF(REQ_A)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3), .y_valid(a_yv),
    .slot(a_slot), .locked(a_lk), .sync_err(a_err)
  );

  tdm_demux #(.W(W), .BIT_SWAP(SWAP_B), .REQUIRE_SOF(REQ_B)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .y0(b_y0), .y1(b_y1), .y2(b_y2), .y3(b_y3), .y_valid(b_yv),
    .slot(b_slot), .locked(b_lk), .sync_err(b_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           lk;
    logic [1:0]     slot;
    logic           err;
    logic           yv;
    logic [4*W-1:0] y;   // {y3, y2, y1, y0}
  } stat_t;

  stat_t          exp_st_a[$], exp_st_b[$];
  logic [4*W-1:0] exp_fr_a[$], exp_fr_b[$];

  int total = 0;
  int bad   = 0;

  // Reference model: a lock flag plus the list of symbols collected so far.
  bit             m_lk[2];
  int             m_n[2];
  logic [W-1:0]   m_buf[2][4];
  logic [4*W-1:0] m_y[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input int d, input bit sw, input bit rq, input logic r,
                            input logic v, input logic sof, input logic [W-1:0] dv,
                            output stat_t st, output bit done);
    logic [W-1:0] s;
    logic err, yv;
    err  = 1'b0;
    yv   = 1'b0;
    done = 1'b0;
    if (r) begin
      m_lk[d] = 1'b0;
      m_n[d]  = 0;
      m_y[d]  = '0;
    end else if (v) begin
      for (int i = 0; i < W; i++) s[i] = sw ? dv[W-1-i] : dv[i];
      if (!m_lk[d]) begin
        if (sof) begin
          m_lk[d] = 1'b1;
          m_buf[d][0] = s;
          m_n[d] = 1;
        end
      end else if (m_n[d] == 0) begin
        if (sof || !rq) begin
          m_buf[d][0] = s;
          m_n[d] = 1;
        end else begin
          err = 1'b1;
          m_lk[d] = 1'b0;
        end
      end else if (sof) begin
        err = 1'b1;
        m_buf[d][0] = s;
        m_n[d] = 1;
      end else begin
        m_buf[d][m_n[d]] = s;
        m_n[d]++;
        if (m_n[d] == SLOTS) begin
          m_y[d] = {m_buf[d][3], m_buf[d][2], m_buf[d][1], m_buf[d][0]};
          yv   = 1'b1;
          done = 1'b1;
          m_n[d] = 0;
        end
      end
    end
    st.lk   = m_lk[d];
    st.slot = m_lk[d] ? 2'(m_n[d]) : 2'd0;
    st.err  = err;
    st.yv   = yv;
    st.y    = m_y[d];
  endtask

  // One clock of stimulus: drive on the falling edge, record predictions for the next rise.
  task automatic cycle(input logic r, input logic v, input logic sof, input logic [W-1:0] dv);
    stat_t st;
    bit done;
    @(negedge clk);
    rst = r;
    din_valid = v;
    din_sof = sof;
    din = dv;
    model_step(0, SWAP_A, REQ_A, r, v, sof, dv, st, done);
    exp_st_a.push_back(st);
    if (done) exp_fr_a.push_back(st.y);
    model_step(1, SWAP_B, REQ_B, r, v, sof, dv, st, done);
    exp_st_b.push_back(st);
    if (done) exp_fr_b.push_back(st.y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic beat(input logic sof, input logic [W-1:0] dv);
    cycle(1'b0, 1'b1, sof, dv);
  endtask

  // Monitor: just after each rising edge compare status against the prediction and
  // pop a full frame from the scoreboard whenever y_valid is presented.
  initial begin
    stat_t e;
    logic [4*W-1:0] f;
    forever begin
      @(posedge clk);
      #1;
      if (exp_st_a.size() > 0) begin
        e = exp_st_a.pop_front();
        check("a_locked", 32'(a_lk), 32'(e.lk));
        check("a_slot", 32'(a_slot), 32'(e.slot));
        check("a_sync_err", 32'(a_err), 32'(e.err));
        check("a_y_valid", 32'(a_yv), 32'(e.yv));
        check("a_y_hold", 32'({a_y3, a_y2, a_y1, a_y0}), 32'(e.y));
      end
      if (exp_st_b.size() > 0) begin
        e = exp_st_b.pop_front();
        check("b_locked", 32'(b_lk), 32'(e.lk));
        check("b_slot", 32'(b_slot), 32'(e.slot));
        check("b_sync_err", 32'(b_err), 32'(e.err));
        check("b_y_valid", 32'(b_yv), 32'(e.yv));
        check("b_y_hold", 32'({b_y3, b_y2, b_y1, b_y0}), 32'(e.y));
      end
      if (a_yv === 1'b1) begin
        if (exp_fr_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_frame at %0t: got unexpected y_valid expected none", $time);
        end else begin
          f = exp_fr_a.pop_front();
          check("a_frame", 32'({a_y3, a_y2, a_y1, a_y0}), 32'(f));
        end
      end
      if (b_yv === 1'b1) begin
        if (exp_fr_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_frame at %0t: got unexpected y_valid expected none", $time);
        end else begin
          f = exp_fr_b.pop_front();
          check("b_frame", 32'({b_y3, b_y2, b_y1, b_y0}), 32'(f));
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized stream with occasional resets.
  initial begin
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Basic frame 1,2,3,0 (straight on a, swapped on b).
    beat(1'b1, 2'd1); beat(1'b0, 2'd2); beat(1'b0, 2'd3); beat(1'b0, 2'd0);
    idle(2);

    // Beats without sof after reset are dropped, then a normal frame.
    cycle(1'b1, 1'b0, 1'b0, '0);
    beat(1'b0, 2'd3); beat(1'b0, 2'd3);
    beat(1'b1, 2'd2); beat(1'b0, 2'd1); beat(1'b0, 2'd1); beat(1'b0, 2'd1);
    idle(1);

    // Mid-frame sof aborts the partial frame and restarts.
    beat(1'b1, 2'd1); beat(1'b0, 2'd2);
    beat(1'b1, 2'd3); beat(1'b0, 2'd0); beat(1'b0, 2'd0); beat(1'b0, 2'd0);
    idle(1);

    // Non-sof beat at a frame boundary: error on a, slot 0 on b.
    beat(1'b0, 2'd2);
    idle(2);

    // Gapped frame, then reset mid-frame.
    cycle(1'b1, 1'b0, 1'b0, '0);
    beat(1'b1, 2'd1); idle(3);
    beat(1'b0, 2'd2); idle(3);
    beat(1'b0, 2'd3); idle(3);
    beat(1'b0, 2'd0); idle(2);
    beat(1'b1, 2'd1); beat(1'b0, 2'd2);
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle(2);

    // Back-to-back frames with sof on every frame start.
    for (int k = 0; k < 8; k++) begin
      beat(1'b1, W'($urandom));
      for (int j = 1; j < SLOTS; j++) beat(1'b0, W'($urandom));
    end

    // Randomized stream.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < 25, W'($urandom));
    end

    idle(3);
    check("a_frames_drained", 32'(exp_fr_a.size()), 32'd0);
    check("b_frames_drained", 32'(exp_fr_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
